// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt stage: byte type, S-box size,
// PRGA state encoding and the printable-plaintext range used by the optional checker.
package rc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int S_AW    = $clog2(S_DEPTH);

    typedef logic [S_AW-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WAIT_I,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J,
        RD_F,
        WAIT_F,
        WR_OUT,
        DONE
    } prga_state_t;

    // Accepted plaintext: lowercase letters and space.
    localparam byte_t PLAIN_LO    = 8'h61;
    localparam byte_t PLAIN_HI    = 8'h7A;
    localparam byte_t PLAIN_SPACE = 8'h20;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Memory-side bus of the PRGA stage: S-box RAM, encrypted ROM and decrypted RAM.
// master = the PRGA engine, slave = the memories.
interface rc4_prga_decrypt_if #(
    parameter int MSG_LEN = 32
);
    import rc4_pkg::*;

    localparam int MSG_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    byte_t             s_address;
    byte_t             s_data;
    logic              s_wren;
    byte_t             s_q;
    logic [MSG_AW-1:0] rom_address;
    byte_t             rom_q;
    logic [MSG_AW-1:0] ram_address;
    byte_t             ram_data;
    logic              ram_wren;

    modport master (
        output s_address, s_data, s_wren,
        input  s_q,
        output rom_address,
        input  rom_q,
        output ram_address, ram_data, ram_wren
    );

    modport slave (
        input  s_address, s_data, s_wren,
        output s_q,
        input  rom_address,
        output rom_q,
        input  ram_address, ram_data, ram_wren
    );

endinterface

// File: rtl/rc4_plain_check.sv
// Combinational printable-plaintext test (a..z or space); exists only when
// RC4_PLAINTEXT_CHECK_EN is defined.
`ifdef RC4_PLAINTEXT_CHECK_EN
module rc4_plain_check
    import rc4_pkg::*;
(
    input  byte_t data,
    output logic  ok
);

    assign ok = ((data >= PLAIN_LO) && (data <= PLAIN_HI)) || (data == PLAIN_SPACE);

endmodule
`endif

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over the S-box left by key scheduling; XORs keystream with ROM bytes into RAM.
// Optional RC4_PLAINTEXT_CHECK_EN adds 'bad' and stops early on a non-printable byte.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               finish,
`ifdef RC4_PLAINTEXT_CHECK_EN
    output logic               bad,
`endif
    rc4_prga_decrypt_if.master mem
);

    localparam int    MSG_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam byte_t LAST_K = byte_t'(MSG_LEN - 1);

    prga_state_t state, state_next;
    byte_t       i, j, k, si, sj, f, enc;
    byte_t       plain;
    logic        stop_early;

    assign plain = f ^ enc;

`ifdef RC4_PLAINTEXT_CHECK_EN
    logic plain_ok;

    rc4_plain_check u_plain_check (
        .data (plain),
        .ok   (plain_ok)
    );

    assign stop_early = ~plain_ok;
`else
    assign stop_early = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the S-box itself lives outside and is deliberately not reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            f     <= '0;
            enc   <= '0;
`ifdef RC4_PLAINTEXT_CHECK_EN
            bad   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
`ifdef RC4_PLAINTEXT_CHECK_EN
                    bad <= 1'b0;
`endif
                end
                RD_I:   i  <= i + 8'd1;
                WAIT_I: si <= mem.s_q;
                RD_J:   j  <= j + si;
                WAIT_J: sj <= mem.s_q;
                WAIT_F: begin
                    f   <= mem.s_q;
                    enc <= mem.rom_q;
                end
                WR_OUT: begin
                    k <= k + 8'd1;
`ifdef RC4_PLAINTEXT_CHECK_EN
                    if (stop_early) bad <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next      = state;
        finish          = 1'b0;
        mem.s_address   = '0;
        mem.s_data      = '0;
        mem.s_wren      = 1'b0;
        mem.rom_address = '0;
        mem.ram_address = '0;
        mem.ram_data    = '0;
        mem.ram_wren    = 1'b0;
        case (state)
            IDLE:   if (start) state_next = RD_I;
            RD_I: begin
                mem.s_address = i + 8'd1;
                state_next    = WAIT_I;
            end
            WAIT_I: state_next = RD_J;
            RD_J: begin
                mem.s_address = j + si;
                state_next    = WAIT_J;
            end
            WAIT_J: state_next = WR_I;
            WR_I: begin
                mem.s_address = i;
                mem.s_data    = sj;
                mem.s_wren    = 1'b1;
                state_next    = WR_J;
            end
            // When i==j this rewrites the same cell with the same value, leaving S intact.
            WR_J: begin
                mem.s_address = j;
                mem.s_data    = si;
                mem.s_wren    = 1'b1;
                state_next    = RD_F;
            end
            RD_F: begin
                mem.s_address   = si + sj;
                mem.rom_address = k[MSG_AW-1:0];
                state_next      = WAIT_F;
            end
            WAIT_F: state_next = WR_OUT;
            WR_OUT: begin
                mem.ram_address = k[MSG_AW-1:0];
                mem.ram_data    = plain;
                mem.ram_wren    = 1'b1;
                state_next      = ((k == LAST_K) || stop_early) ? DONE : RD_I;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt with 1-cycle-latency models of S RAM, ROM and RAM.
// Expected bytes come from hand-computed vectors and an independent software RC4 loop.
module tb_rc4_prga_decrypt;
    import rc4_pkg::*;

    localparam int MSG_LEN = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic finish;
`ifdef RC4_PLAINTEXT_CHECK_EN
    logic bad;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    byte_t s_mem [S_DEPTH];
    byte_t rom   [MSG_LEN];
    byte_t ram   [MSG_LEN];
    byte_t m_s   [S_DEPTH];
    byte_t m_out [MSG_LEN];
    byte_t snap2, snap3;

    rc4_prga_decrypt_if #(.MSG_LEN(MSG_LEN)) mem_if ();

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .finish  (finish),
`ifdef RC4_PLAINTEXT_CHECK_EN
        .bad     (bad),
`endif
        .mem     (mem_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_if.s_wren) s_mem[mem_if.s_address] <= mem_if.s_data;
        mem_if.s_q   <= s_mem[mem_if.s_address];
        mem_if.rom_q <= rom[mem_if.rom_address];
        if (mem_if.ram_wren) ram[mem_if.ram_address] <= mem_if.ram_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_mems(input byte_t rom0, input byte_t rom1);
        for (int n = 0; n < S_DEPTH; n++) s_mem[n] = byte_t'(n);
        for (int n = 0; n < MSG_LEN; n++) begin
            rom[n] = 8'h00;
            ram[n] = 8'hEE;
        end
        rom[0] = rom0;
        rom[1] = rom1;
    endtask

    task automatic model_prime();
        for (int n = 0; n < S_DEPTH; n++) m_s[n] = s_mem[n];
    endtask

    // Plain software RC4 PRGA on m_s, fresh i=j=0.
    task automatic model_run();
        byte_t mi, mj, t;
        mi = '0;
        mj = '0;
        for (int n = 0; n < MSG_LEN; n++) begin
            mi = mi + 8'd1;
            mj = mj + m_s[mi];
            t = m_s[mi];
            m_s[mi] = m_s[mj];
            m_s[mj] = t;
            m_out[n] = m_s[byte_t'(m_s[mi] + m_s[mj])] ^ rom[n];
        end
    endtask

    function automatic int ram_diff();
        int d = 0;
        for (int n = 0; n < MSG_LEN; n++) if (ram[n] !== m_out[n]) d++;
        return d;
    endfunction

    function automatic int s_diff();
        int d = 0;
        for (int n = 0; n < S_DEPTH; n++) if (s_mem[n] !== m_s[n]) d++;
        return d;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {29'd0, finish, mem_if.s_wren, mem_if.ram_wren}, 32'd0);
        check({tag, "_s"}, {16'd0, mem_if.s_address, mem_if.s_data}, 32'd0);
        check({tag, "_mem"}, {19'd0, mem_if.rom_address, mem_if.ram_address, mem_if.ram_data}, 32'd0);
    endtask

    // Cycle c is the negedge after edge c-1 counted from the edge that samples start.
    task automatic run(input int limit, input int reset_at, input bit pulses, input bit hold,
                       output int fin1, output int fin2, output int n_fin,
                       output int n_swr, output int n_rwr);
        fin1 = -1; fin2 = -1; n_fin = 0; n_swr = 0; n_rwr = 0;
        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clock);
            if (!hold) start = pulses && (c == 5 || c == 100);
            if (c == 18) begin
                snap2 = s_mem[2];
                snap3 = s_mem[3];
            end
            if (c == reset_at) begin
                reset_n = 1'b0;
                start   = 1'b0;
                #1;
                check_outputs_zero("midrun_rst");
                return;
            end
            if (finish) begin
                n_fin++;
                if (fin1 < 0) fin1 = c;
                else if (fin2 < 0) fin2 = c;
            end
            n_swr += int'(mem_if.s_wren);
            n_rwr += int'(mem_if.ram_wren);
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    int fin1, fin2, n_fin, n_swr, n_rwr;

    initial begin
        init_mems(8'h00, 8'h00);
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_outputs_zero("idle");

`ifdef RC4_PLAINTEXT_CHECK_EN
        run(40, 0, 1'b0, 1'b0, fin1, fin2, n_fin, n_swr, n_rwr);
        check("early_finish", fin1, 10);
        check("early_ram_wr", n_rwr, 1);
        check("early_ram0", ram[0], 8'h02);
        check("early_ram1_untouched", ram[1], 8'hEE);
        check("bad_set", bad, 1'b1);
        check("single_finish", n_fin, 1);
`else
        // Identity S, zero ROM: output is raw keystream.
        model_prime();
        model_run();
        run(300, 0, 1'b0, 1'b0, fin1, fin2, n_fin, n_swr, n_rwr);
        check("a_finish_edge", fin1, 289);
        check("a_finish_pulses", n_fin, 1);
        check("a_s_writes", n_swr, 2 * MSG_LEN);
        check("a_ram_writes", n_rwr, MSG_LEN);
        check("a_ram0", ram[0], 8'h02);
        check("a_ram1", ram[1], 8'h05);
        check("a_s2_after_b1", snap2, 8'd3);
        check("a_s3_after_b1", snap3, 8'd2);
        check("a_ram_vs_model", ram_diff(), 0);
        check("a_s_vs_model", s_diff(), 0);

        // Nonzero ciphertext, stray start pulses mid-run.
        init_mems(8'h68, 8'h65);
        model_prime();
        model_run();
        run(300, 0, 1'b1, 1'b0, fin1, fin2, n_fin, n_swr, n_rwr);
        check("b_ram0", ram[0], 8'h6A);
        check("b_ram1", ram[1], 8'h60);
        check("b_finish_edge", fin1, 289);
        check("b_finish_pulses", n_fin, 1);
        check("b_ram_vs_model", ram_diff(), 0);

        // Reset mid-run, then restart from i=j=0 over the partially permuted S.
        init_mems(8'h68, 8'h65);
        run(300, 40, 1'b0, 1'b0, fin1, fin2, n_fin, n_swr, n_rwr);
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 0; n < MSG_LEN; n++) ram[n] = 8'hEE;
        model_prime();
        model_run();
        run(300, 0, 1'b0, 1'b0, fin1, fin2, n_fin, n_swr, n_rwr);
        check("c_finish_edge", fin1, 289);
        check("c_ram_vs_model", ram_diff(), 0);
        check("c_s_vs_model", s_diff(), 0);

        // start held high: DONE->IDLE then immediate second run on the permuted S.
        init_mems(8'h00, 8'h00);
        model_prime();
        model_run();
        model_run();
        run(579, 0, 1'b0, 1'b1, fin1, fin2, n_fin, n_swr, n_rwr);
        check("d_finish1", fin1, 289);
        check("d_finish2", fin2, 579);
        check("d_ram_vs_model", ram_diff(), 0);
        check("d_s_writes", n_swr, 4 * MSG_LEN);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
